sim_ctrl_sequencer: RTL and testbench
=====================================

# sim_ctrl_sequencer

Parametrised, synthesizable simulation-control sequencer. It drives a configurable multi-pulse reset train into the DUT and then periodically polls one or more host channels (fesvr-style tick/exit words) over a valid/ready handshake. It aggregates per-channel exit words into a single sticky pass/fail/timeout verdict. It sits beside `testharness` in the simulation top and replaces free-running delay loops with cycle-exact, multi-channel control.

## Interface
- `NumChannels`, 1: number of polled host channels (1..16).
- `DataWidth`, 32: width of a channel exit word (≥2).
- `ResetPulses`, 2: number of DUT reset low phases (≥1).
- `ResetLowCycles`, 10: cycles per low phase (≥1).
- `ResetHighCycles`, 10: cycles per intermediate high phase (≥1).
- `PollCycles`, 200: idle cycles between poll rounds (≥1).
- `MaxPolls`, 0: poll-round limit before timeout; 0 disables the timeout.
- Derived `CW` = max(1, $clog2(NumChannels)).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: begins the sequence; sampled only in IDLE.
- `dut_rst_no` out 1: DUT reset, active low.
- `poll_req_o` out 1: poll request valid.
- `poll_chan_o` out CW: channel being polled.
- `poll_rsp_valid_i` in 1: host response; completes the handshake when `poll_req_o` is high.
- `poll_rsp_data_i` in DataWidth: exit word; 0 means the channel is still running.
- `chan_done_o` out NumChannels: per-channel terminated flags.
- `done_o` out 1: sequence finished (sticky).
- `success_o` out 1: all channels exited with code 0.
- `timeout_o` out 1: poll limit reached.
- `exit_code_o` out DataWidth-1: code of the first failing channel.
- `fail_chan_o` out CW: index of the first failing or undone channel.

## Operation
- **States:** IDLE → RST_LO ⇄ RST_HI → POLL ⇄ WAIT → DONE.
- **IDLE:** `dut_rst_no`=0. If `start_i`=1, go to RST_LO with pulse count 1.
- **RST_LO:** `dut_rst_no`=0 for ResetLowCycles cycles.
  - If pulse count < ResetPulses, go to RST_HI.
  - Otherwise go to POLL.
- **RST_HI:** `dut_rst_no`=1 for ResetHighCycles cycles, then increment the pulse count and return to RST_LO.
- **POLL and later:** `dut_rst_no`=1 until `rst_i`.
- **POLL round:** visit channels whose `chan_done_o` bit is clear, in ascending index.
  - For each, hold `poll_req_o`=1 with `poll_chan_o`=index until `poll_rsp_valid_i`=1.
  - A nonzero word sets `chan_done_o[idx]` and stores code = data[DataWidth-1:1].
  - A zero word leaves the channel open.
  - Advance to the next undone channel in the cycle after the handshake.
  - After the last channel, increment the round counter.
- **Round end:**
  - All channels done → DONE.
  - Else, if MaxPolls≠0 and rounds == MaxPolls → DONE with timeout.
  - Else → WAIT.
- **WAIT:** count PollCycles cycles, then return to POLL.
- **DONE:** sticky until `rst_i`. `done_o`=1 and `poll_req_o`=0.
  - Normal completion: `success_o`=1 iff every stored code is 0; otherwise `exit_code_o` and `fail_chan_o` report the lowest-index nonzero code.
  - Timeout: `timeout_o`=1, `success_o`=0, `exit_code_o`=0, `fail_chan_o` = lowest undone index.
- **Ignored inputs:** `poll_rsp_valid_i` while `poll_req_o`=0, and `start_i` outside IDLE.

## Timing
- **Reset values:** `dut_rst_no`=0, `poll_req_o`=0, `poll_chan_o`=0, `chan_done_o`=0, `done_o`=0, `success_o`=0, `timeout_o`=0, `exit_code_o`=0, `fail_chan_o`=0.
- **Mid-operation reset:** `rst_i` at any state applies the values above in the next cycle, including while a request is pending; that response is dropped.
- **Start latency:** `start_i` high in IDLE at cycle t gives `dut_rst_no`=0 from t+1. The DUT reset is asserted for exactly ResetLowCycles cycles per pulse.
- **Default pattern:** low 10, high 10, low 10, then high permanently.
- **First poll:** `poll_req_o` rises in the first cycle after the final low phase.
- **Handshake:** zero-wait response is allowed (request and valid high in the same cycle). The request deasserts or changes channel in the next cycle. `poll_chan_o` is stable while `poll_req_o`=1.
- **Poll spacing:** the next round's first request follows the last handshake of the previous round by exactly PollCycles+1 cycles.
- **Verdict:** `done_o` and the verdict outputs are registered. They rise one cycle after the final handshake and all change in the same cycle.
- **Counters:**
  - Cycle counter: $clog2 of the max of the cycle parameters, plus 1 bit.
  - Round counter: saturates at MaxPolls; wrap-around is not permitted.
  - With MaxPolls=0 the round counter is unused and polling continues indefinitely.

## Test plan
- **Reset train:** defaults, `start_i` pulse → `dut_rst_no` pattern 0×10, 1×10, 0×10, then 1; `poll_req_o` rises in the next cycle.
- **Single-channel success:** host returns 0, 0, 1 → three rounds spaced 201 cycles apart; `done_o`=1, `success_o`=1, `exit_code_o`=0.
- **Three-channel failure:** ch0 returns 1, ch2 returns 7 (code 3), ch1 returns 5 (code 2) a round later → done channels are not re-polled; `exit_code_o`=2, `fail_chan_o`=1.
- **Timeout:** MaxPolls=4, host always returns 0 → after round 4, `timeout_o`=1, `success_o`=0, `fail_chan_o`=0.
- **Handshake stress:** random 0–5 cycle response delay, zero-wait responses, and spurious valid with no request → `poll_chan_o` is stable while requested, and spurious responses have no effect.
- **Mid-operation reset:** `rst_i` mid-POLL with a request pending → all outputs return to reset values next cycle; a restart via `start_i` repeats the full reset train.

Source files
------------

// File: rtl/sim_ctrl_sequencer.sv
// sim_ctrl_sequencer
//
// Simulation-control sequencer that sits beside the test harness. It does
// three things:
//   1. Drives a multi-pulse, active-low reset train into the DUT after start.
//   2. Polls one or more host channels over a valid/ready style handshake.
//   3. Folds the per-channel exit words into one sticky verdict.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   start_i          starts the sequence (only looked at while idle)
//   dut_rst_no       DUT reset, active low
//   poll_req_o       poll request valid
//   poll_chan_o      channel being polled
//   poll_rsp_valid_i host response; completes the handshake while poll_req_o=1
//   poll_rsp_data_i  exit word; zero means the channel is still running
//   chan_done_o      per-channel terminated flags
//   done_o           sequence finished (sticky)
//   success_o        every channel exited with code 0
//   timeout_o        poll-round limit reached
//   exit_code_o      code of the first failing channel
//   fail_chan_o      index of the first failing (or, on timeout, undone) channel
module sim_ctrl_sequencer #(
    parameter int NumChannels     = 1,
    parameter int DataWidth       = 32,
    parameter int ResetPulses     = 2,
    parameter int ResetLowCycles  = 10,
    parameter int ResetHighCycles = 10,
    parameter int PollCycles      = 200,
    parameter int MaxPolls        = 0,
    localparam int CW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   dut_rst_no,
    output logic                   poll_req_o,
    output logic [CW-1:0]          poll_chan_o,
    input  logic                   poll_rsp_valid_i,
    input  logic [DataWidth-1:0]   poll_rsp_data_i,
    output logic [NumChannels-1:0] chan_done_o,
    output logic                   done_o,
    output logic                   success_o,
    output logic                   timeout_o,
    output logic [DataWidth-2:0]   exit_code_o,
    output logic [CW-1:0]          fail_chan_o
);

    localparam int MaxCyc = (ResetLowCycles > ResetHighCycles)
                          ? ((ResetLowCycles > PollCycles) ? ResetLowCycles : PollCycles)
                          : ((ResetHighCycles > PollCycles) ? ResetHighCycles : PollCycles);
    localparam int CNTW = $clog2(MaxCyc) + 1;
    localparam int PW   = $clog2(ResetPulses + 1);
    localparam int RW   = (MaxPolls > 0) ? $clog2(MaxPolls + 1) : 1;

    localparam logic [CNTW-1:0] LO_LAST   = CNTW'(ResetLowCycles - 1);
    localparam logic [CNTW-1:0] HI_LAST   = CNTW'(ResetHighCycles - 1);
    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(PollCycles - 1);
    localparam logic [PW-1:0]   PULSES    = PW'(ResetPulses);
    localparam logic [RW-1:0]   ROUND_MAX = RW'(MaxPolls);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LO, S_RST_HI, S_POLL, S_WAIT, S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNTW-1:0]          cnt_reg, cnt_next;
    logic [PW-1:0]            pulse_reg, pulse_next;
    logic [CW-1:0]            chan_reg, chan_next;
    logic [RW-1:0]            round_reg, round_next, round_inc;
    logic [NumChannels-1:0]   mask_reg, mask_next, mask_upd;
    logic                     done_reg, done_next;
    logic                     success_reg, success_next;
    logic                     timeout_reg, timeout_next;
    logic [DataWidth-2:0]     exit_code_reg, exit_code_next;
    logic [CW-1:0]            fail_chan_reg, fail_chan_next;

    logic                     hs;
    logic                     rsp_nz;
    logic [DataWidth-2:0]     code_reg [NumChannels];
    // Stored codes as they will look after this cycle's handshake, so the
    // verdict can be computed in the same cycle as the final handshake.
    logic [DataWidth-2:0]     code_upd [NumChannels];
    logic [NumChannels-1:0]   code_nz;

    assign hs     = (state_reg == S_POLL) && poll_rsp_valid_i;
    assign rsp_nz = |poll_rsp_data_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumChannels; gi++) begin : g_chan
            logic chan_hit;
            assign chan_hit = hs && rsp_nz && (chan_reg == CW'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    code_reg[gi] <= '0;
                end else if (chan_hit) begin
                    code_reg[gi] <= poll_rsp_data_i[DataWidth-1:1];
                end
            end

            assign code_upd[gi] = chan_hit ? poll_rsp_data_i[DataWidth-1:1] : code_reg[gi];
            assign mask_upd[gi] = mask_reg[gi] | chan_hit;
            assign code_nz[gi]  = |code_upd[gi];
        end
    endgenerate

    function automatic logic [CW-1:0] lowest_clear(input logic [NumChannels-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (!m[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    // Next undone channel above the current one, judged on the updated mask.
    logic          next_found;
    logic [CW-1:0] next_chan;
    always_comb begin
        next_found = 1'b0;
        next_chan  = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if ((CW'(i) > chan_reg) && !mask_upd[i]) begin
                next_found = 1'b1;
                next_chan  = CW'(i);
            end
        end
    end

    // Lowest-index channel that reported a nonzero code.
    logic                 fail_found;
    logic [CW-1:0]        fail_idx;
    logic [DataWidth-2:0] fail_code;
    always_comb begin
        fail_found = 1'b0;
        fail_idx   = '0;
        fail_code  = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (code_nz[i]) begin
                fail_found = 1'b1;
                fail_idx   = CW'(i);
                fail_code  = code_upd[i];
            end
        end
    end

    // Round counter saturates at the limit so it can never wrap.
    assign round_inc = (round_reg != ROUND_MAX) ? round_reg + 1'b1 : round_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            pulse_reg     <= '0;
            chan_reg      <= '0;
            round_reg     <= '0;
            mask_reg      <= '0;
            done_reg      <= 1'b0;
            success_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            exit_code_reg <= '0;
            fail_chan_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pulse_reg     <= pulse_next;
            chan_reg      <= chan_next;
            round_reg     <= round_next;
            mask_reg      <= mask_next;
            done_reg      <= done_next;
            success_reg   <= success_next;
            timeout_reg   <= timeout_next;
            exit_code_reg <= exit_code_next;
            fail_chan_reg <= fail_chan_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pulse_next     = pulse_reg;
        chan_next      = chan_reg;
        round_next     = round_reg;
        mask_next      = mask_reg;
        done_next      = done_reg;
        success_next   = success_reg;
        timeout_next   = timeout_reg;
        exit_code_next = exit_code_reg;
        fail_chan_next = fail_chan_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_RST_LO;
                    cnt_next   = '0;
                    pulse_next = PW'(1);
                end
            end
            S_RST_LO: begin
                if (cnt_reg == LO_LAST) begin
                    cnt_next = '0;
                    if (pulse_reg < PULSES) begin
                        state_next = S_RST_HI;
                    end else begin
                        state_next = S_POLL;
                        chan_next  = lowest_clear(mask_reg);
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RST_HI: begin
                if (cnt_reg == HI_LAST) begin
                    cnt_next   = '0;
                    pulse_next = pulse_reg + 1'b1;
                    state_next = S_RST_LO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_POLL: begin
                if (hs) begin
                    mask_next = mask_upd;
                    if (next_found) begin
                        chan_next = next_chan;
                    end else begin
                        round_next = round_inc;
                        if (&mask_upd) begin
                            state_next     = S_DONE;
                            done_next      = 1'b1;
                            success_next   = !fail_found;
                            exit_code_next = fail_code;
                            fail_chan_next = fail_idx;
                        end else if ((MaxPolls != 0) && (round_inc == ROUND_MAX)) begin
                            state_next     = S_DONE;
                            done_next      = 1'b1;
                            timeout_next   = 1'b1;
                            success_next   = 1'b0;
                            exit_code_next = '0;
                            fail_chan_next = lowest_clear(mask_upd);
                        end else begin
                            state_next = S_WAIT;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_POLL;
                    chan_next  = lowest_clear(mask_reg);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign dut_rst_no  = !((state_reg == S_IDLE) || (state_reg == S_RST_LO));
    assign poll_req_o  = (state_reg == S_POLL);
    assign poll_chan_o = chan_reg;
    assign chan_done_o = mask_reg;
    assign done_o      = done_reg;
    assign success_o   = success_reg;
    assign timeout_o   = timeout_reg;
    assign exit_code_o = exit_code_reg;
    assign fail_chan_o = fail_chan_reg;

endmodule

// File: tb/tb_sim_ctrl_sequencer.sv
// Directed testbench for sim_ctrl_sequencer. Three instances with different
// parameter sets share one clock and the response bus:
//   u0  defaults (1 channel, 2 reset pulses, 200 poll cycles)
//   u1  3 channels, short timing, no poll limit
//   u2  2 channels, short timing, MaxPolls = 4
module tb_sim_ctrl_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  rst;
    logic [2:0]  start;
    logic        valid;
    logic [31:0] data;

    logic        rstn0, req0, done0, succ0, tmo0;
    logic [0:0]  chan0, cdone0, fchan0;
    logic [30:0] code0;

    logic        rstn1, req1, done1, succ1, tmo1;
    logic [1:0]  chan1, fchan1;
    logic [2:0]  cdone1;
    logic [30:0] code1;

    logic        rstn2, req2, done2, succ2, tmo2;
    logic [0:0]  chan2, fchan2;
    logic [1:0]  cdone2;
    logic [30:0] code2;

    sim_ctrl_sequencer u0 (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .dut_rst_no(rstn0),
        .poll_req_o(req0), .poll_chan_o(chan0), .poll_rsp_valid_i(valid),
        .poll_rsp_data_i(data), .chan_done_o(cdone0), .done_o(done0),
        .success_o(succ0), .timeout_o(tmo0), .exit_code_o(code0), .fail_chan_o(fchan0)
    );

    sim_ctrl_sequencer #(
        .NumChannels(3), .ResetPulses(1), .ResetLowCycles(3),
        .ResetHighCycles(2), .PollCycles(4), .MaxPolls(0)
    ) u1 (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .dut_rst_no(rstn1),
        .poll_req_o(req1), .poll_chan_o(chan1), .poll_rsp_valid_i(valid),
        .poll_rsp_data_i(data), .chan_done_o(cdone1), .done_o(done1),
        .success_o(succ1), .timeout_o(tmo1), .exit_code_o(code1), .fail_chan_o(fchan1)
    );

    sim_ctrl_sequencer #(
        .NumChannels(2), .ResetPulses(1), .ResetLowCycles(2),
        .ResetHighCycles(1), .PollCycles(3), .MaxPolls(4)
    ) u2 (
        .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .dut_rst_no(rstn2),
        .poll_req_o(req2), .poll_chan_o(chan2), .poll_rsp_valid_i(valid),
        .poll_rsp_data_i(data), .chan_done_o(cdone2), .done_o(done2),
        .success_o(succ2), .timeout_o(tmo2), .exit_code_o(code2), .fail_chan_o(fchan2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Step to just after the next active edge; outputs are stable here and
    // inputs set here are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_req(input int id);
        case (id)
            0:       return req0;
            1:       return req1;
            default: return req2;
        endcase
    endfunction

    function automatic int cur_chan(input int id);
        case (id)
            0:       return int'(chan0);
            1:       return int'(chan1);
            default: return int'(chan2);
        endcase
    endfunction

    // Wait (bounded) for a request; optionally drive spurious responses
    // while no request is outstanding.
    task automatic wait_req(input int id, input bit spur, output bit ok);
        int budget;
        budget = 400;
        ok = 1'b1;
        while (!cur_req(id)) begin
            if (budget == 0) begin
                check("wait_req_bound", 64'd0, 64'd1);
                ok = 1'b0;
                valid = 1'b0;
                return;
            end
            budget--;
            if (spur && (cyc - hs_cyc >= 5) && (cyc - hs_cyc <= 10)) begin
                valid = 1'b1;
                data  = 32'h0000_000B;
            end else begin
                valid = 1'b0;
                data  = '0;
            end
            tick();
        end
        valid = 1'b0;
        data  = '0;
    endtask

    // Answer one request after 'delay' idle cycles; returns one cycle after
    // the handshake.
    task automatic serve(input int id, input int exp_chan, input logic [31:0] d, input int delay);
        bit ok;
        wait_req(id, 1'b0, ok);
        if (!ok) return;
        check("poll_chan", 64'(cur_chan(id)), 64'(exp_chan));
        for (int k = 0; k < delay; k++) begin
            tick();
            check("req_held", 64'(cur_req(id)), 64'd1);
            check("chan_stable", 64'(cur_chan(id)), 64'(exp_chan));
        end
        valid  = 1'b1;
        data   = d;
        hs_cyc = cyc;
        tick();
        valid = 1'b0;
        data  = '0;
    endtask

    // Start u0 from IDLE and check the default 0x10, 1x10, 0x10, 1 train,
    // with the first request in the cycle right after the last low phase.
    task automatic check_train0();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            check("rst_train", 64'(rstn0), ((k <= 10) || (k >= 21 && k <= 30)) ? 64'd0 : 64'd1);
            check("train_req", 64'(req0), (k == 31) ? 64'd1 : 64'd0);
            if (k < 31) tick();
        end
    endtask

    initial begin
        bit ok;
        int r;
        rst   = 3'b111;
        start = 3'b000;
        valid = 1'b0;
        data  = '0;
        tick();
        tick();
        // Reset values
        check("rst_dut_rst_no", 64'(rstn0), 64'd0);
        check("rst_req", 64'(req0), 64'd0);
        check("rst_chan", 64'(chan0), 64'd0);
        check("rst_chan_done", 64'(cdone0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_success", 64'(succ0), 64'd0);
        check("rst_timeout", 64'(tmo0), 64'd0);
        check("rst_exit_code", 64'(code0), 64'd0);
        check("rst_fail_chan", 64'(fchan0), 64'd0);
        rst = 3'b000;
        tick();
        check("idle_dut_rst_no", 64'(rstn0), 64'd0);

        // Reset train and single-channel success: 0, 0, 1.
        check_train0();
        serve(0, 0, 32'd0, 0);
        wait_req(0, 1'b1, ok);
        check("spacing_r2", 64'(cyc - hs_cyc), 64'd201);
        check("spurious_no_effect", 64'(cdone0), 64'd0);
        serve(0, 0, 32'd0, 3);
        check("r2_not_done", 64'(done0), 64'd0);
        wait_req(0, 1'b0, ok);
        check("spacing_r3", 64'(cyc - hs_cyc), 64'd201);
        serve(0, 0, 32'd1, 0);
        check("s1_done", 64'(done0), 64'd1);
        check("s1_success", 64'(succ0), 64'd1);
        check("s1_exit_code", 64'(code0), 64'd0);
        check("s1_timeout", 64'(tmo0), 64'd0);
        check("s1_chan_done", 64'(cdone0), 64'd1);
        check("s1_req_low", 64'(req0), 64'd0);
        repeat (5) tick();
        check("s1_sticky", 64'(done0), 64'd1);

        // Three-channel failure, zero-wait back-to-back handshakes.
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        serve(1, 0, 32'd1, 0);
        serve(1, 1, 32'd0, 0);
        serve(1, 2, 32'd7, 2);
        check("f3_mask_r1", 64'(cdone1), 64'b101);
        check("f3_not_done", 64'(done1), 64'd0);
        serve(1, 1, 32'd5, 1);
        check("f3_done", 64'(done1), 64'd1);
        check("f3_success", 64'(succ1), 64'd0);
        check("f3_exit_code", 64'(code1), 64'd2);
        check("f3_fail_chan", 64'(fchan1), 64'd1);
        check("f3_timeout", 64'(tmo1), 64'd0);
        check("f3_chan_done", 64'(cdone1), 64'b111);

        // Timeout after 4 rounds with random response delays.
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        for (int rd = 1; rd <= 4; rd++) begin
            serve(2, 0, 32'd0, int'($urandom_range(5, 0)));
            serve(2, 1, 32'd0, int'($urandom_range(5, 0)));
            check("to_done_round", 64'(done2), (rd == 4) ? 64'd1 : 64'd0);
        end
        check("to_timeout", 64'(tmo2), 64'd1);
        check("to_success", 64'(succ2), 64'd0);
        check("to_exit_code", 64'(code2), 64'd0);
        check("to_fail_chan", 64'(fchan2), 64'd0);
        check("to_chan_done", 64'(cdone2), 64'd0);

        // Mid-operation reset with a request pending; response is dropped.
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        tick();
        check_train0();
        tick();
        tick();
        check("pend_req", 64'(req0), 64'd1);
        rst[0] = 1'b1;
        valid  = 1'b1;
        data   = 32'd9;
        tick();
        rst[0] = 1'b0;
        valid  = 1'b0;
        data   = '0;
        check("mr_dut_rst_no", 64'(rstn0), 64'd0);
        check("mr_req", 64'(req0), 64'd0);
        check("mr_chan_done", 64'(cdone0), 64'd0);
        check("mr_done", 64'(done0), 64'd0);
        check("mr_success", 64'(succ0), 64'd0);
        check("mr_exit_code", 64'(code0), 64'd0);
        tick();
        check("mr_idle_req", 64'(req0), 64'd0);
        check_train0();
        serve(0, 0, 32'd3, 0);
        r = int'(code0);
        check("mr_fail_done", 64'(done0), 64'd1);
        check("mr_fail_success", 64'(succ0), 64'd0);
        check("mr_fail_code", 64'(r), 64'd1);
        check("mr_fail_chan", 64'(fchan0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
